// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. Receives a little-endian byte stream
// (16-bit word count N, then N 32-bit words, LSB first) over a valid/ready
// handshake. It writes each assembled word to consecutive word-aligned
// addresses starting at 0, and holds the core in reset until the image is in
// memory.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   rx_data_i   stream byte
//   rx_valid_i  rx_data_i holds a valid byte
//   rx_ready_o  loader accepts a byte this cycle
//   wr_en_o     instruction memory write strobe (one cycle per word)
//   wr_addr_o   byte address of the write, word aligned
//   wr_data_o   instruction word to write
//   core_rst_o  core reset, released once the load completes
//   done_o      image loaded (sticky until rst_i)
//   error_o     header word count exceeds capacity (sticky until rst_i)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int AddressWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic                    wr_en_o,
  output logic [AddressWidth-1:0] wr_addr_o,
  output logic [31:0]             wr_data_o,
  output logic                    core_rst_o,
  output logic                    done_o,
  output logic                    error_o
);

  localparam int IdxW = AddressWidth - 2;
  // Capacity in words, held in 17 bits so N == capacity compares cleanly.
  localparam logic [16:0] Capacity = 17'(2 ** IdxW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_CHECK,
    S_WORD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       word_q, word_d;

  logic              rx_ready_q;
  logic              wr_en_q;
  logic [AddressWidth-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;

  logic              accept;

  // The ready flag comes from a register, so the handshake never depends
  // combinationally on rx_valid_i.
  assign accept = rx_valid_i & rx_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE: state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = rx_data_i;
          state_d    = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = rx_data_i;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else if ({1'b0, cnt_q} > Capacity) begin
          state_d = S_ERROR;
        end else begin
          idx_d   = '0;
          byte_d  = 2'd0;
          state_d = S_WORD;
        end
      end
      S_WORD: begin
        if (accept) begin
          word_d[{byte_q, 3'b000} +: 8] = rx_data_i;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The index may wrap to 0 after the last word of a full image; it is
        // never used again because the next state is DONE.
        idx_d = idx_q + 1'b1;
        if (17'(idx_q) + 17'd1 == {1'b0, cnt_q}) begin
          state_d = S_DONE;
        end else begin
          byte_d  = 2'd0;
          state_d = S_WORD;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the
  // same cycle that the FSM occupies the matching state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      word_q     <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      word_q     <= word_d;
      rx_ready_q <= (state_d == S_CNT_LO) || (state_d == S_CNT_HI) ||
                    (state_d == S_WORD);
      wr_en_q    <= (state_d == S_WRITE);
      if (state_q == S_WORD && state_d == S_WRITE) begin
        wr_addr_q <= {idx_q, 2'b00};
        wr_data_q <= word_d;
      end
      core_rst_q <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign core_rst_o = core_rst_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Bench for imem_loader. The driver sends byte streams. An image model
// computes the expected writes, one per word at address 4*i, and queues them.
// A separate monitor pops the queue and compares it on every wr_en_o pulse.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int CAP = 2 ** (AW - 2);

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [31:0]   wr_data_o;
  logic          core_rst_o;
  logic          done_o;
  logic          error_o;

  imem_loader #(.AddressWidth(AW)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .core_rst_o(core_rst_o),
    .done_o    (done_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] img[0:255];
  int          nvec = 0;
  int          nerr = 0;
  int          last_wr_cyc = 0;
  logic [AW-1:0] last_wr_addr = '0;
  bit          first_wr = 1'b1;
  bit          chk_spacing = 1'b0;
  logic        prev_wr_en = 1'b0;
  int          acc_cyc = 0;
  int          end_cyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endfunction

  // Monitor: checks every write against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && wr_en_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {22'd0, wr_addr_o}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {22'd0, wr_addr_o}, {22'd0, e.addr});
        chk("wr_data", wr_data_o, e.data);
        chk("wr_pulse_1cyc", {31'd0, prev_wr_en}, 32'd0);
        if (chk_spacing && !first_wr)
          chk("wr_spacing", cyc - last_wr_cyc, 32'd5);
      end
      last_wr_cyc  = cyc;
      last_wr_addr = wr_addr_o;
      first_wr     = 1'b0;
    end
    prev_wr_en = wr_en_o;
  end

  function automatic int gap(input int m);
    if (m == 0) return 0;
    return int'($urandom_range(0, m));
  endfunction

  // Offer one byte; return just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input int g);
    int t;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      rx_valid_i = 1'b0;
      rx_data_i  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    t = 0;
    while (!rx_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    @(negedge clk);
    rx_valid_i = 1'b0;
    while (!(done_o || error_o) && t < 200) begin
      @(negedge clk);
      t++;
    end
    end_cyc = cyc;
    chk("end_timeout", {31'd0, t < 200}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    // Still before the next rising edge: the outputs must already be at their reset values.
    chk("async_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("async_wr_en",    {31'd0, wr_en_o},    32'd0);
    chk("async_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("async_done",     {31'd0, done_o},     32'd0);
    chk("async_error",    {31'd0, error_o},    32'd0);
    sb.delete();
    first_wr = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_wr_addr", {22'd0, wr_addr_o}, 32'd0);
    chk("rst_wr_data", wr_data_o, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    @(negedge clk);
    chk("ready_2nd_cycle", {31'd0, rx_ready_o}, 32'd1);
  endtask

  // Load an N-word header plus the first N entries of img (none if N is too large).
  task automatic load(input int n, input int maxgap);
    int nw;
    logic [15:0] nn;
    nn = 16'(n);
    nw = (n <= CAP) ? n : 0;
    for (int i = 0; i < nw; i++) sb.push_back('{addr: AW'(i * 4), data: img[i]});
    first_wr = 1'b1;
    send_byte(nn[7:0], gap(maxgap));
    send_byte(nn[15:8], gap(maxgap));
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w = img[i];
        send_byte(w[8*k +: 8], gap(maxgap));
      end
    wait_end();
    repeat (3) @(negedge clk);
    chk("done",     {31'd0, done_o},     {31'd0, n <= CAP});
    chk("error",    {31'd0, error_o},    {31'd0, n > CAP});
    chk("core_rst", {31'd0, core_rst_o}, {31'd0, n > CAP});
    chk("rx_ready_after", {31'd0, rx_ready_o}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = $urandom;

    // Reset values while rst_i is high.
    @(negedge clk);
    chk("rst_core_rst", {31'd0, core_rst_o}, 32'd1);
    chk("rst_wr_en",    {31'd0, wr_en_o},    32'd0);
    do_reset();

    // N=2 gapless, with fixed instruction words.
    img[0] = 32'h00A0_0513;
    img[1] = 32'h00A5_85B3;
    chk_spacing = 1'b1;
    load(2, 0);
    chk_spacing = 1'b0;
    chk("done_after_last_write", 32'(end_cyc - last_wr_cyc), 32'd1);

    // Surplus bytes after done are never accepted.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid_i = 1'b1;
      rx_data_i  = 8'($urandom);
      chk("post_done_ready", {31'd0, rx_ready_o}, 32'd0);
      chk("post_done_done",  {31'd0, done_o},     32'd1);
    end

    // N=0: done one cycle after CHECK.
    do_reset();
    load(0, 0);
    chk("n0_done_timing", 32'(end_cyc - acc_cyc), 32'd1);

    // N=257 overflows; N=256 fills memory exactly.
    do_reset();
    load(CAP + 1, 0);
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    load(CAP, 0);
    chk("full_last_addr", {22'd0, last_wr_addr}, 32'h3FC);

    // N=3, gapless and then with random stalls; both checked against the same model.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    do_reset();
    load(3, 0);
    do_reset();
    load(3, 7);

    // Reset in the middle of word 1, then reload with a fresh header.
    do_reset();
    img[0] = $urandom;
    img[1] = $urandom;
    sb.push_back('{addr: AW'(0), data: img[0]});
    sb.push_back('{addr: AW'(4), data: img[1]});
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = img[0];
      send_byte(w[8*k +: 8], 0);
    end
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    do_reset();
    img[0] = 32'hDEAD_BEEF;
    load(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
